// File: rtl/score_keeper_if.sv
// score_keeper_if
// Bundles the game-control inputs and score-record outputs of score_keeper.
//   master : the game controller side (drives new_game, player_id,
//            game_timeout, Current_Score; reads the records)
//   slave  : score_keeper itself (reads the controls, drives Highest_Score,
//            Personel_Best, Player_Won, record_flag, busy)
// ID_W must equal $clog2(NUM_PLAYERS) of the attached score_keeper.
interface score_keeper_if #(
  parameter int ID_W = 2
);
  logic            new_game;
  logic [ID_W-1:0] player_id;
  logic            game_timeout;
  logic [6:0]      Current_Score;
  logic [6:0]      Highest_Score;
  logic [6:0]      Personel_Best;
  logic [2:0]      Player_Won;
  logic            record_flag;
  logic            busy;

  modport master (
    output new_game, player_id, game_timeout, Current_Score,
    input  Highest_Score, Personel_Best, Player_Won, record_flag, busy
  );

  modport slave (
    input  new_game, player_id, game_timeout, Current_Score,
    output Highest_Score, Personel_Best, Player_Won, record_flag, busy
  );
endinterface

// File: rtl/score_keeper.sv
// score_keeper
// Per-player record keeper. When a game ends (rising edge of game_timeout
// while PLAYING) it captures the clamped final score, updates that player's
// personal best and the all-time high score, and counts record-setting games.
// Ports:
//   clk   : system clock, all updates on the rising edge
//   reset : synchronous, active-high
//   bus   : score_keeper_if.slave
//           in : new_game, player_id, game_timeout, Current_Score
//           out: Highest_Score, Personel_Best, Player_Won, record_flag, busy
module score_keeper #(
  parameter int NUM_PLAYERS = 4,
  parameter int MAX_SCORE   = 99
) (
  input logic           clk,
  input logic           reset,
  score_keeper_if.slave bus
);
  localparam int         ID_W    = $clog2(NUM_PLAYERS);
  localparam logic [6:0] MAX_S   = 7'(MAX_SCORE);
  localparam logic [2:0] WON_MAX = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    PLAYING,
    CAPTURE,
    UPDATE,
    DONE
  } state_t;

  state_t          state;
  logic [ID_W-1:0] active_id;
  logic [6:0]      best [NUM_PLAYERS];
  logic [6:0]      highest;
  logic [6:0]      final_score;
  logic [2:0]      won;
  logic            record;
  logic            timeout_q;
  logic            busy_q;
  logic [6:0]      clamped;

  // Scores beyond the two-digit display range are pinned to the ceiling
  // before any comparison so an overflowed counter cannot claim a record.
  always_comb begin
    clamped = (bus.Current_Score > MAX_S) ? MAX_S : bus.Current_Score;
  end

  // Game FSM plus all record storage. timeout_q follows game_timeout in every
  // state, so a level that is already high when PLAYING is entered looks like
  // "previous = 1" and never fakes an end-of-game edge. busy is registered
  // from the state being entered so it lines up exactly with PLAYING,
  // CAPTURE and UPDATE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      active_id   <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        best[i] <= '0;
      end
      highest     <= '0;
      final_score <= '0;
      won         <= '0;
      record      <= 1'b0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      timeout_q <= bus.game_timeout;
      case (state)
        IDLE: begin
          if (bus.new_game) begin
            active_id <= bus.player_id;
            record    <= 1'b0;
            busy_q    <= 1'b1;
            state     <= PLAYING;
          end
        end
        PLAYING: begin
          if (bus.game_timeout && !timeout_q) begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          final_score <= clamped;
          state       <= UPDATE;
        end
        UPDATE: begin
          // Strictly-greater comparisons: a tie leaves every record alone.
          if (final_score > best[active_id]) begin
            best[active_id] <= final_score;
          end
          if (final_score > highest) begin
            highest <= final_score;
            record  <= 1'b1;
            if (won != WON_MAX) begin
              won <= won + 3'd1;
            end
          end
          busy_q <= 1'b0;
          state  <= DONE;
        end
        DONE: begin
          // A new game may start straight from DONE without waiting for
          // game_timeout to drop.
          if (bus.new_game) begin
            active_id <= bus.player_id;
            record    <= 1'b0;
            busy_q    <= 1'b1;
            state     <= PLAYING;
          end else if (!bus.game_timeout) begin
            state <= IDLE;
          end
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // Personal best always reflects the currently latched player, so it
  // switches on the same edge that latches a new player_id.
  assign bus.Highest_Score = highest;
  assign bus.Personel_Best = best[active_id];
  assign bus.Player_Won    = won;
  assign bus.record_flag   = record;
  assign bus.busy          = busy_q;
endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper
// Directed bench for score_keeper (NUM_PLAYERS=4, MAX_SCORE=99). Each game's
// expected records and commit cycle are queued when the game is issued; an
// independent process compares them whenever busy falls.
module tb_score_keeper;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;
  logic busy_prev = 1'b0;

  typedef struct {
    logic [6:0] hs;
    logic [6:0] pb;
    logic [2:0] won;
    logic       rec;
    int         at_cyc;
  } exp_t;

  exp_t sb[$];

  score_keeper_if #(.ID_W(2)) bus ();

  score_keeper #(
    .NUM_PLAYERS(4),
    .MAX_SCORE  (99)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Free-running clock with a cycle counter used to time commits.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // One comparison: counts it and reports a mismatch on a single line.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Every falling edge of busy is a finished (or reset-aborted) game; pair it
  // with the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (busy_prev === 1'b1 && bus.busy === 1'b0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_commit: busy fell at cycle %0d with nothing expected", cyc);
      end else begin
        e = sb.pop_front();
        checkOutput("Highest_Score", int'(bus.Highest_Score), int'(e.hs));
        checkOutput("Personel_Best", int'(bus.Personel_Best), int'(e.pb));
        checkOutput("Player_Won",    int'(bus.Player_Won),    int'(e.won));
        checkOutput("record_flag",   int'(bus.record_flag),   int'(e.rec));
        checkOutput("commit_cycle",  cyc,                     e.at_cyc);
      end
    end
    busy_prev = bus.busy;
  end

  // Checks every record output directly against constants.
  task automatic checkIdle(input string tag, input int hs, input int pb,
                           input int won, input int rec, input int busy);
    checkOutput({tag, "_hs"},   int'(bus.Highest_Score), hs);
    checkOutput({tag, "_pb"},   int'(bus.Personel_Best), pb);
    checkOutput({tag, "_won"},  int'(bus.Player_Won),    won);
    checkOutput({tag, "_rec"},  int'(bus.record_flag),   rec);
    checkOutput({tag, "_busy"}, int'(bus.busy),          busy);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    bus.new_game = 1'b0;
    bus.game_timeout = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Pulses new_game for a player and confirms the personal best switches to
  // that player's slot. If game_timeout is still high from the last game it
  // is held for a few cycles first (must not commit), then released.
  task automatic startGame(input int pid, input int pb_start);
    bus.new_game  = 1'b1;
    bus.player_id = 2'(pid);
    @(negedge clk);
    bus.new_game = 1'b0;
    checkOutput("pb_after_latch", int'(bus.Personel_Best), pb_start);
    checkOutput("busy_playing",   int'(bus.busy), 1);
    if (bus.game_timeout) begin
      repeat (3) @(negedge clk);
      checkOutput("busy_held_high", int'(bus.busy), 1);
      bus.game_timeout = 1'b0;
      @(negedge clk);
    end
  endtask

  // Plays one full game and queues the records expected after its commit,
  // two cycles after the edge that first samples game_timeout high.
  task automatic applyStimulus(input int pid, input int score, input int pb_start,
                               input int e_hs, input int e_pb, input int e_won,
                               input int e_rec, input bit drop_after);
    exp_t e;
    startGame(pid, pb_start);
    bus.Current_Score = 7'(score);
    bus.game_timeout  = 1'b1;
    e.hs = 7'(e_hs); e.pb = 7'(e_pb); e.won = 3'(e_won); e.rec = 1'(e_rec);
    e.at_cyc = cyc + 3;
    sb.push_back(e);
    repeat (4) @(negedge clk);
    if (drop_after) begin
      bus.game_timeout = 1'b0;
      @(negedge clk);
    end
  endtask

  // Starts a game, lets the end-of-game edge happen, then resets while the
  // FSM is capturing: the score must be discarded and everything cleared.
  task automatic resetDuringCapture(input int pid, input int pb_start);
    exp_t e;
    startGame(pid, pb_start);
    bus.Current_Score = 7'd90;
    bus.game_timeout  = 1'b1;
    e.hs = '0; e.pb = '0; e.won = '0; e.rec = 1'b0;
    e.at_cyc = cyc + 2;
    @(negedge clk);
    reset = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    reset = 1'b0;
    bus.game_timeout = 1'b0;
    @(negedge clk);
    checkIdle("after_mid_reset", 0, 0, 0, 0, 0);
  endtask

  // Main sequence.
  initial begin
    bus.new_game      = 1'b0;
    bus.player_id     = '0;
    bus.game_timeout  = 1'b0;
    bus.Current_Score = '0;
    doReset();
    checkIdle("reset", 0, 0, 0, 0, 0);

    // A timeout pulse while idle must not change anything.
    bus.Current_Score = 7'd55;
    bus.game_timeout  = 1'b1;
    repeat (2) @(negedge clk);
    bus.game_timeout = 1'b0;
    repeat (2) @(negedge clk);
    checkIdle("idle_pulse", 0, 0, 0, 0, 0);

    //             pid score pb0  hs  pb won rec drop
    applyStimulus(1,  42,   0,  42, 42, 1,  1,  1'b0);
    applyStimulus(2,  30,   0,  42, 30, 1,  0,  1'b1);
    applyStimulus(1,  42,  42,  42, 42, 1,  0,  1'b0);
    applyStimulus(3, 120,   0,  99, 99, 2,  1,  1'b1);
    applyStimulus(3, 100,  99,  99, 99, 2,  0,  1'b1);

    doReset();
    checkIdle("reset2", 0, 0, 0, 0, 0);

    // Eight record games 10..80 across the four slots; the win count pins at 7.
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(i % 4, 10 * i, (i > 4) ? 10 * (i - 4) : 0,
                    10 * i, 10 * i, (i < 7) ? i : 7, 1, i[0]);
    end

    resetDuringCapture(0, 80);

    applyStimulus(2, 5, 0, 5, 5, 1, 1, 1'b1);

    for (int w = 0; w < 50 && sb.size() > 0; w++) @(negedge clk);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL missing_commit: expected at cycle %0d, still pending at cycle %0d", e.at_cyc, cyc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/score_keeper.md
# score_keeper

Per-player record keeper that writes the score records read by the score updater. When a game ends, it captures the final Current_Score, updates that player's personal best and the all-time highest score, and counts how many games set a new high score. The score updater reads Highest_Score, Personel_Best and Player_Won from this block for its end-of-game display.

## Interface
Parameters:
- NUM_PLAYERS, default 4: number of player record slots; must be a power of two, 2..8.
- MAX_SCORE, default 99: saturation ceiling for captured scores, matching the two-digit display.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- new_game  input  1  single-cycle pulse that starts a game for player_id.
- player_id  input  $clog2(NUM_PLAYERS)  player slot; sampled only on an accepted new_game.
- game_timeout  input  1  level; high while the game is over.
- Current_Score  input  7  live score from the score updater.
- Highest_Score  output  7  maximum committed score across all players.
- Personel_Best  output  7  personal best of the active (latched) player.
- Player_Won  output  3  count of games that set a new Highest_Score; saturates at 7.
- record_flag  output  1  high from commit until the next accepted new_game when the last game set a new Highest_Score.
- busy  output  1  high in PLAYING, CAPTURE and UPDATE.

## Operation
- States: IDLE, PLAYING, CAPTURE, UPDATE, DONE.
- IDLE: on new_game=1, latch player_id into active_id, clear record_flag, go to PLAYING.
- PLAYING: track game_timeout with a one-cycle registered copy. On a rising edge (game_timeout=1, previous=0), go to CAPTURE.
- CAPTURE: final = min(Current_Score, MAX_SCORE), registered. Go to UPDATE.
- UPDATE:
  - If final > best[active_id], write best[active_id] = final.
  - If final > Highest_Score, write Highest_Score = final, set record_flag, and increment Player_Won unless it is already 7.
  - Equal scores update nothing.
  - Go to DONE.
- DONE: return to IDLE when game_timeout=0, or go directly to PLAYING when new_game=1 (latch the new player_id and clear record_flag).
- new_game in PLAYING, CAPTURE or UPDATE is ignored.
- A game_timeout level already high when PLAYING is entered does not trigger a commit. A low-to-high transition is required.
- Personel_Best = best[active_id] at all times, including immediately after a new player is latched.
- Arithmetic: all comparisons are unsigned 7-bit. Scores above MAX_SCORE (100..127) are clamped before comparison.
- reset clears all best[] entries, Highest_Score, Player_Won, record_flag, active_id and the edge register, and puts the FSM in IDLE.
- A reset asserted mid-game discards the in-flight score. The reset value applies on the next edge.

## Timing
- Reset values: Highest_Score=0, Personel_Best=0, Player_Won=0, record_flag=0, busy=0.
- Edge E: game_timeout is sampled high with the previous sample low, and the FSM enters CAPTURE.
- E+1: final is registered from Current_Score as sampled at E+1.
- E+2: the UPDATE writes are visible on the outputs, and the FSM is in DONE.
- Commit latency from the first high sample of game_timeout to updated outputs is therefore 2 cycles.
- busy falls at E+2.
- new_game → PLAYING: active_id and Personel_Best reflect the new player on the next edge.
- Player_Won: exactly one increment per game, at most.

## Test plan
- Reset then idle: all outputs 0, busy=0; a game_timeout pulse in IDLE causes no change.
- Player 1 new_game, Current_Score=42, game_timeout rises → 2 cycles later Highest_Score=42, Personel_Best=42, Player_Won=1, record_flag=1.
- Player 2 scores 30, then player 1 scores 42 again:
  - After player 2: Personel_Best=30, Highest_Score=42, record_flag=0.
  - After player 1's tie: Player_Won stays 1 and best[1] stays 42.
- Current_Score=120 at capture → clamped to 99; Highest_Score=99.
- Eight successive record-setting games (10, 20, ..., 80) → Player_Won stays 7 after the seventh game; Highest_Score=80.
- reset asserted one cycle after the game_timeout edge (during CAPTURE) → all outputs 0, FSM in IDLE, no commit; a following new_game works normally.
